// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment digit type, segment patterns and anode helpers
package seg7_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    function automatic logic [3:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to active-low 7-segment decoder
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [6:0]  seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_mux.sv
// rtl/bcd_seg_mux.sv - 4-digit multiplexed 7-segment driver with guard cycle and leading-zero blanking
module bcd_seg_mux
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd,
    input  logic        bcd_load,
    input  logic        blank_lz,
    input  logic        en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [1:0]  dig_sel
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]  presc;
    logic [1:0]        idx;
    logic [15:0]       disp_reg;
    bcd_digit_t [3:0]  digits;
    bcd_digit_t        cur_digit;
    logic [6:0]        seg_dec;
    logic              slot_end;
    logic              blanked;
    logic [3:0]        an_next;

    assign digits    = disp_reg;
    assign cur_digit = digits[idx];
    assign slot_end  = (presc == CNT_MAX);

    bcd_to_seg7 u_dec (
        .digit (cur_digit),
        .seg   (seg_dec)
    );

    always_comb begin
        blanked = 1'b0;
        if (blank_lz) begin
            case (idx)
                2'd3:    blanked = (digits[3] == 4'd0);
                2'd2:    blanked = (digits[3] == 4'd0) && (digits[2] == 4'd0);
                2'd1:    blanked = (digits[3] == 4'd0) && (digits[2] == 4'd0) && (digits[1] == 4'd0);
                default: blanked = 1'b0;
            endcase
        end
    end

    // Prescaler at zero is the first cycle of a slot: keep anodes off while the digit switches
    always_comb begin
        an_next = an_select(idx);
        if (presc == '0 || !en || blanked)
            an_next = AN_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            idx      <= 2'd0;
            disp_reg <= 16'h0000;
            an       <= AN_OFF;
            seg      <= SEG_OFF;
            dig_sel  <= 2'd0;
        end else begin
            presc <= slot_end ? '0 : presc + 1'b1;
            if (slot_end)
                idx <= idx + 2'd1;
            if (bcd_load)
                disp_reg <= bcd;
            an      <= an_next;
            seg     <= seg_dec;
            dig_sel <= idx;
        end
    end

endmodule

// File: tb/tb_bcd_seg_mux.sv
// tb/tb_bcd_seg_mux.sv - directed self-checking bench for bcd_seg_mux with REFRESH_DIV = 4
module tb_bcd_seg_mux;

    logic        clk;
    logic        rst;
    logic [15:0] bcd;
    logic        bcd_load;
    logic        blank_lz;
    logic        en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  dig_sel;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PD = 7'b0111111;
    localparam logic [6:0] PX = 7'b1111111;

    bcd_seg_mux #(.REFRESH_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd      (bcd),
        .bcd_load (bcd_load),
        .blank_lz (blank_lz),
        .en       (en),
        .an       (an),
        .seg      (seg),
        .dig_sel  (dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full slot: guard cycle then three active cycles; optional load lands on the wrap edge
    task automatic run_slot(input logic [1:0] sel, input logic [3:0] exp_an, input logic [6:0] exp_seg,
                            input logic blz, input logic e, input logic ld, input logic [15:0] ldv);
        blank_lz = blz;
        en       = e;
        tick();
        check("guard_an", 16'(an), 16'hF);
        check("guard_sel", 16'(dig_sel), 16'(sel));
        for (int k = 0; k < 3; k++) begin
            if (k == 2 && ld) begin
                bcd      = ldv;
                bcd_load = 1'b1;
            end
            tick();
            check("slot_an", 16'(an), 16'(exp_an));
            check("slot_sel", 16'(dig_sel), 16'(sel));
            if (exp_an != 4'hF)
                check("slot_seg", 16'(seg), 16'(exp_seg));
        end
        bcd_load = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        bcd      = 16'h8888;
        bcd_load = 1'b1;
        blank_lz = 1'b0;
        en       = 1'b1;
        tick();
        tick();
        check("rst_an", 16'(an), 16'hF);
        check("rst_seg", 16'(seg), 16'(PX));
        check("rst_sel", 16'(dig_sel), 16'h0);
        rst      = 1'b0;
        bcd_load = 1'b0;

        // Load during reset was dropped: display starts at 0000
        run_slot(2'd0, 4'b1110, P0, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd1, 4'b1101, P0, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd2, 4'b1011, P0, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd3, 4'b0111, P0, 1'b0, 1'b1, 1'b1, 16'h1234);

        // Scan order with 1234
        run_slot(2'd0, 4'b1110, P4, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd1, 4'b1101, P3, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd2, 4'b1011, P2, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd3, 4'b0111, P1, 1'b0, 1'b1, 1'b1, 16'h0007);

        // 0007 without blanking
        run_slot(2'd0, 4'b1110, P7, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd1, 4'b1101, P0, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd2, 4'b1011, P0, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd3, 4'b0111, P0, 1'b0, 1'b1, 1'b0, 16'h0);

        // 0007 with blanking
        run_slot(2'd0, 4'b1110, P7, 1'b1, 1'b1, 1'b0, 16'h0);
        run_slot(2'd1, 4'b1111, P0, 1'b1, 1'b1, 1'b0, 16'h0);
        run_slot(2'd2, 4'b1111, P0, 1'b1, 1'b1, 1'b0, 16'h0);
        run_slot(2'd3, 4'b1111, P0, 1'b1, 1'b1, 1'b1, 16'h0405);

        // Interior zero 0405 with blanking
        run_slot(2'd0, 4'b1110, P5, 1'b1, 1'b1, 1'b0, 16'h0);
        run_slot(2'd1, 4'b1101, P0, 1'b1, 1'b1, 1'b0, 16'h0);
        run_slot(2'd2, 4'b1011, P4, 1'b1, 1'b1, 1'b0, 16'h0);
        run_slot(2'd3, 4'b1111, P0, 1'b1, 1'b1, 1'b1, 16'h00A0);

        // Non-BCD digit shows a dash
        run_slot(2'd0, 4'b1110, P0, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd1, 4'b1101, PD, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd2, 4'b1011, P0, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd3, 4'b0111, P0, 1'b0, 1'b1, 1'b0, 16'h0);

        // Display disabled: anodes off, index keeps running
        run_slot(2'd0, 4'b1111, P0, 1'b0, 1'b0, 1'b0, 16'h0);
        run_slot(2'd1, 4'b1111, P0, 1'b0, 1'b0, 1'b0, 16'h0);
        run_slot(2'd2, 4'b1111, P0, 1'b0, 1'b0, 1'b0, 16'h0);
        run_slot(2'd3, 4'b1111, P0, 1'b0, 1'b0, 1'b0, 16'h0);

        // Load on the wrap into slot 2; contents unaffected by en being low earlier
        run_slot(2'd0, 4'b1110, P0, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd1, 4'b1101, PD, 1'b0, 1'b1, 1'b1, 16'h9999);
        run_slot(2'd2, 4'b1011, P9, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd3, 4'b0111, P9, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd0, 4'b1110, P9, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd1, 4'b1101, P9, 1'b0, 1'b1, 1'b0, 16'h0);

        // Reset in the middle of slot 2
        tick();
        check("mid_guard_an", 16'(an), 16'hF);
        check("mid_guard_sel", 16'(dig_sel), 16'h2);
        tick();
        check("mid_an", 16'(an), 16'(4'b1011));
        check("mid_seg", 16'(seg), 16'(P9));
        rst = 1'b1;
        tick();
        check("mrst_an", 16'(an), 16'hF);
        check("mrst_seg", 16'(seg), 16'(PX));
        check("mrst_sel", 16'(dig_sel), 16'h0);
        tick();
        check("mrst_hold_an", 16'(an), 16'hF);
        check("mrst_hold_seg", 16'(seg), 16'(PX));
        rst = 1'b0;
        run_slot(2'd0, 4'b1110, P0, 1'b0, 1'b1, 1'b0, 16'h0);
        run_slot(2'd1, 4'b1101, P0, 1'b0, 1'b1, 1'b0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
